dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates one single-port data RAM between two requesters.
- Master 0 is the cpu6 core load/store port; it can read and write, with byte enables for sb/sh/lh/lb.
- Master 1 is the VGA scan-out fetcher; it is read-only.
- Sits in soc_top between the core/VGA and the shared RAM instance. It provides round-robin arbitration, an urgent override for the VGA line fetch, and a starvation guard for the CPU.

Parameters:
- AW, 12, word-address width; RAM depth is 2^AW words of 32 bits.
- STARVE_LIMIT, 4, maximum consecutive cycles m0 may be denied while requesting before it is force-granted; legal range 1..15.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- m0_req, input, 1, CPU request; held with its attributes stable until m0_gnt.
- m0_we, input, 1, 1 = write, 0 = read.
- m0_addr, input, AW, CPU word address.
- m0_wdata, input, 32, write data.
- m0_be, input, 4, byte enables for writes; ignored on reads.
- m0_gnt, output, 1, request accepted this cycle.
- m0_rvalid, output, 1, read data valid; one cycle after a granted read.
- m0_rdata, output, 32, read data.
- m1_req, input, 1, VGA read request; held stable until m1_gnt.
- m1_urgent, input, 1, VGA line buffer below watermark.
- m1_addr, input, AW, VGA word address.
- m1_gnt, output, 1, request accepted this cycle.
- m1_rvalid, output, 1, read data valid; one cycle after a granted read.
- m1_rdata, output, 32, read data.
- mem_en, output, 1, RAM access strobe.
- mem_we, output, 4, RAM per-byte write enables.
- mem_addr, output, AW, RAM address.
- mem_wdata, output, 32, RAM write data.
- mem_rdata, input, 32, RAM read data; valid the cycle after mem_en with mem_we==0.

Behaviour:
- Reset values:
  - all gnt, rvalid, mem_en, mem_we are 0.
  - rdata outputs and mem_addr/mem_wdata are 0.
  - last_grant = 1, so the first contention goes to m0.
  - starve_cnt = 0.
  - rd_owner valid = 0.
- Grant is combinational from the current request, current state and counter; at most one gnt per cycle. Priority, evaluated in order:
  1. m0_req && starve_cnt == STARVE_LIMIT -> grant m0.
  2. m1_req && m1_urgent -> grant m1.
  3. Both requesting -> grant the master not equal to last_grant.
  4. Otherwise grant the single requester, if any.
- On any grant, last_grant is registered to the granted master at the next clk edge.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) each cycle m0_req=1 and m0_gnt=0.
  - clears to 0 when m0_gnt=1 or m0_req=0.
- Memory drive in the grant cycle, all combinational:
  - mem_addr comes from the granted master.
  - m0 write: mem_en=1, mem_we=m0_be, mem_wdata=m0_wdata.
  - m0 write with m0_be==0: grant still given, but mem_en=0 and no RAM access (no-op store).
  - read: mem_en=1, mem_we=0.
  - no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata keep their last values (no toggling).
- Read return:
  - a granted read registers rd_owner (valid + master id).
  - the next cycle, the owner's rvalid=1 and its rdata=mem_rdata; the other master's rvalid=0.
  - rdata outputs hold their last value when rvalid=0.
  - writes never produce rvalid.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating masters are legal, with a read return overlapping the next grant.
- Simultaneous events:
  - urgent m1 vs. starving m0: m0 wins.
  - the m1_urgent deassert/assert edge has no effect beyond the current-cycle decision.
- Reset mid-operation: a pending read return is discarded (no rvalid after reset release), and counters and pointer return to their reset values.
- Worst-case m0 latency is STARVE_LIMIT+1 cycles; m1 is unbounded only while m0 is continuously starving, which cannot recur within STARVE_LIMIT cycles after an m0 grant.

Test Plan:
- Single reads/writes:
  - after reset, m0 writes addr 0x010, data 0x12345678, be=4'b1111.
  - m0 then writes be=4'b0011, data 0x0000ffff.
  - m0 reads 0x010 -> m0_gnt same cycle, m0_rvalid one cycle later with rdata 0x1234ffff; m1_rvalid stays 0.
- Round-robin:
  - m0 and m1 both request continuously, m1_urgent=0 -> grants alternate m0, m1, m0, m1.
  - each rvalid is routed to the correct master with rdata from its own address (preload 0x020=0xAAAA0000, 0x040=0x5555FFFF).
- Urgent override and starvation (STARVE_LIMIT=4):
  - m1_req=1, m1_urgent=1, and m0_req=1 held.
  - m1 is granted for 4 cycles and m0 is granted on the 5th.
  - m1 is then granted again on the 6th.
- No-op store: m0 write with be=0 -> m0_gnt=1, mem_en=0, and RAM contents unchanged on readback.
- Reset during read:
  - grant an m1 read, then assert reset in the following cycle before the rvalid edge.
  - after release, m1_rvalid=0, last_grant=1, and the first contention is granted to m0.
- Idle: no requests for 10 cycles -> mem_en=0 throughout, and mem_addr is unchanged from the last access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data RAM: cpu6 load/store port (m0) and VGA scan-out reader (m1).
// Round-robin with VGA urgent override, bounded by a CPU starvation guard.
module dmem_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_urgent,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          last_grant_q;
  logic [CW-1:0] starve_q, starve_d;
  logic          rd_valid_q, rd_owner_q;
  logic [31:0]   m0_rdata_q, m1_rdata_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          g0, g1, rd_start;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (m0_req && starve_q == LIMIT)      g0 = 1'b1;
    else if (m1_req && m1_urgent)         g1 = 1'b1;
    else if (m0_req && m1_req) begin
      if (last_grant_q) g0 = 1'b1;
      else              g1 = 1'b1;
    end
    else if (m0_req)                      g0 = 1'b1;
    else if (m1_req)                      g1 = 1'b1;
  end

  assign m0_gnt   = g0;
  assign m1_gnt   = g1;
  assign rd_start = (g0 && !m0_we) || g1;

  // Address and write data hold their last driven value while idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (g0) begin
      mem_addr = m0_addr;
      if (m0_we) begin
        mem_wdata = m0_wdata;
        mem_we    = m0_be;
        mem_en    = |m0_be;
      end else begin
        mem_en = 1'b1;
      end
    end else if (g1) begin
      mem_addr = m1_addr;
      mem_en   = 1'b1;
    end
  end

  always_comb begin
    starve_d = '0;
    if (m0_req && !g0)
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
  end

  assign m0_rvalid = rd_valid_q && !rd_owner_q;
  assign m1_rvalid = rd_valid_q &&  rd_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : m0_rdata_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      starve_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      rd_valid_q <= rd_start;
      if (rd_start) rd_owner_q <= g1;
      if (g0 || g1) begin
        last_grant_q <= g1;
        mem_addr_q   <= mem_addr;
      end
      if (g0 && m0_we) mem_wdata_q <= m0_wdata;
      if (m0_rvalid) m0_rdata_q <= mem_rdata;
      if (m1_rvalid) m1_rdata_q <= mem_rdata;
    end
  end

endmodule
